ecpri_tx: RTL and testbench

//  eCPRI remote-memory-access response transmitter; the counterpart of the eCPRI RX parser.
//  On a read/write response request it emits one Ethernet frame as a byte stream:
//  - 14-byte Ethernet header read from the header template RAM (port 0).
//  - 4-byte eCPRI common header, then 12-byte RMA header, both generated internally.
//  - Read responses only: N payload bytes read from the payload RAM (port 2).

---
 rtl/ecpri_tx.sv | 213 +++++++++++++++++++++
 tb/tb_ecpri_tx.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecpri_tx.sv
// eCPRI remote-memory-access response transmitter: builds one Ethernet frame per request
// from a header template RAM, generated eCPRI/RMA headers and an optional payload RAM.
module ecpri_tx #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned ETH_HDR_LEN = 14,
   parameter logic [3:0]  ECPRI_REV   = 4'h1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  send_read_resp,
   input  logic                  send_write_resp,
   input  logic [7:0]            resp_payload_len,
   input  logic [7:0]            rm_acc_id,
   input  logic [15:0]           rm_ele_id,
   input  logic [47:0]           rm_addr,
   output logic [ADDR_WIDTH-1:0] addr_0,
   input  logic [DATA_WIDTH-1:0] data_0,
   output logic                  oe_0,
   output logic [ADDR_WIDTH-1:0] addr_2,
   input  logic [DATA_WIDTH-1:0] data_2,
   output logic                  oe_2,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   output logic                  tx_sof,
   output logic                  tx_eof,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic [15:0]           pkt_count
);

   typedef enum logic [2:0] {
      StIdle, StEthFetch, StEthLoad, StEcpriHdr, StRmaHdr, StPlFetch, StPlLoad, StDone
   } state_e;

   state_e      state_q;
   logic        rd_pend_q, wr_pend_q;
   // Request fields are held per pending slot so a request queued while busy keeps its values.
   logic [7:0]  rd_len_q, rd_acc_q, wr_len_q, wr_acc_q;
   logic [15:0] rd_ele_q, wr_ele_q;
   logic [47:0] rd_addr_q, wr_addr_q;
   logic        is_rd_q;
   logic [7:0]  len_q, acc_q;
   logic [15:0] ele_q;
   logic [47:0] addr_q;
   logic [3:0]  idx_q;

   logic [15:0] ps;
   logic        hdr_last;
   logic [3:0]  idx_nxt;

   assign ps       = is_rd_q ? (16'(len_q) + 16'd12) : 16'd12;
   assign hdr_last = !is_rd_q || (len_q == 8'd0);
   assign idx_nxt  = idx_q + 4'd1;

   // Byte i of the 16-byte eCPRI common header + RMA header.
   function automatic logic [DATA_WIDTH-1:0] hdr_byte(input logic [3:0] i);
      logic [7:0] b;
      case (i)
         4'd0:    b = {ECPRI_REV, 4'h0};
         4'd1:    b = 8'h04;
         4'd2:    b = ps[15:8];
         4'd3:    b = ps[7:0];
         4'd4:    b = acc_q;
         4'd5:    b = {(is_rd_q ? 4'h0 : 4'h1), 4'h1};
         4'd6:    b = ele_q[15:8];
         4'd7:    b = ele_q[7:0];
         4'd8:    b = addr_q[47:40];
         4'd9:    b = addr_q[39:32];
         4'd10:   b = addr_q[31:24];
         4'd11:   b = addr_q[23:16];
         4'd12:   b = addr_q[15:8];
         4'd13:   b = addr_q[7:0];
         4'd14:   b = 8'h00;
         default: b = len_q;
      endcase
      return DATA_WIDTH'(b);
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         rd_pend_q <= 1'b0;
         wr_pend_q <= 1'b0;
         rd_len_q  <= '0;
         rd_acc_q  <= '0;
         rd_ele_q  <= '0;
         rd_addr_q <= '0;
         wr_len_q  <= '0;
         wr_acc_q  <= '0;
         wr_ele_q  <= '0;
         wr_addr_q <= '0;
         is_rd_q   <= 1'b0;
         len_q     <= '0;
         acc_q     <= '0;
         ele_q     <= '0;
         addr_q    <= '0;
         idx_q     <= '0;
         addr_0    <= '0;
         oe_0      <= 1'b0;
         addr_2    <= '0;
         oe_2      <= 1'b0;
         tx_data   <= '0;
         tx_valid  <= 1'b0;
         tx_sof    <= 1'b0;
         tx_eof    <= 1'b0;
         busy      <= 1'b0;
         pkt_count <= '0;
      end else begin
         oe_0 <= 1'b0;
         oe_2 <= 1'b0;
         if (send_read_resp && !rd_pend_q) begin
            rd_pend_q <= 1'b1;
            rd_len_q  <= resp_payload_len;
            rd_acc_q  <= rm_acc_id;
            rd_ele_q  <= rm_ele_id;
            rd_addr_q <= rm_addr;
         end
         if (send_write_resp && !wr_pend_q) begin
            wr_pend_q <= 1'b1;
            wr_len_q  <= resp_payload_len;
            wr_acc_q  <= rm_acc_id;
            wr_ele_q  <= rm_ele_id;
            wr_addr_q <= rm_addr;
         end

         case (state_q)
            StIdle: begin
               if (rd_pend_q || wr_pend_q) begin
                  is_rd_q <= rd_pend_q;
                  len_q   <= rd_pend_q ? rd_len_q  : wr_len_q;
                  acc_q   <= rd_pend_q ? rd_acc_q  : wr_acc_q;
                  ele_q   <= rd_pend_q ? rd_ele_q  : wr_ele_q;
                  addr_q  <= rd_pend_q ? rd_addr_q : wr_addr_q;
                  if (rd_pend_q) rd_pend_q <= 1'b0;
                  else           wr_pend_q <= 1'b0;
                  busy    <= 1'b1;
                  addr_0  <= '0;
                  oe_0    <= 1'b1;
                  state_q <= StEthFetch;
               end
            end
            StEthFetch: state_q <= StEthLoad;
            StEthLoad: begin
               if (!tx_valid) begin
                  tx_data  <= data_0;
                  tx_valid <= 1'b1;
                  tx_sof   <= (addr_0 == '0);
               end else if (tx_ready) begin
                  tx_valid <= 1'b0;
                  tx_sof   <= 1'b0;
                  if (addr_0 == ADDR_WIDTH'(ETH_HDR_LEN - 1)) begin
                     idx_q   <= '0;
                     state_q <= StEcpriHdr;
                  end else begin
                     addr_0  <= addr_0 + 1'b1;
                     oe_0    <= 1'b1;
                     state_q <= StEthFetch;
                  end
               end
            end
            StEcpriHdr, StRmaHdr: begin
               if (!tx_valid) begin
                  tx_data  <= hdr_byte(idx_q);
                  tx_valid <= 1'b1;
                  tx_eof   <= (idx_q == 4'd15) && hdr_last;
               end else if (tx_ready) begin
                  if (tx_eof) begin
                     tx_valid <= 1'b0;
                     tx_eof   <= 1'b0;
                     state_q  <= StDone;
                  end else if (idx_q == 4'd15) begin
                     tx_valid <= 1'b0;
                     addr_2   <= '0;
                     oe_2     <= 1'b1;
                     state_q  <= StPlFetch;
                  end else begin
                     // Back-to-back: next header byte replaces the one just taken.
                     idx_q   <= idx_nxt;
                     tx_data <= hdr_byte(idx_nxt);
                     tx_eof  <= (idx_nxt == 4'd15) && hdr_last;
                     state_q <= (idx_nxt >= 4'd4) ? StRmaHdr : StEcpriHdr;
                  end
               end
            end
            StPlFetch: state_q <= StPlLoad;
            StPlLoad: begin
               if (!tx_valid) begin
                  tx_data  <= data_2;
                  tx_valid <= 1'b1;
                  tx_eof   <= (addr_2 == ADDR_WIDTH'(len_q) - ADDR_WIDTH'(1));
               end else if (tx_ready) begin
                  tx_valid <= 1'b0;
                  if (tx_eof) begin
                     tx_eof  <= 1'b0;
                     state_q <= StDone;
                  end else begin
                     addr_2  <= addr_2 + 1'b1;
                     oe_2    <= 1'b1;
                     state_q <= StPlFetch;
                  end
               end
            end
            default: begin
               pkt_count <= pkt_count + 16'd1;
               busy      <= 1'b0;
               state_q   <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ecpri_tx.sv
// Bench for ecpri_tx: table vectors, hand-written corner sequences and random frames,
// all compared against a byte-level frame model built from the header/payload memories.
module tb_ecpri_tx;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        send_read_resp = 1'b0, send_write_resp = 1'b0;
   logic [7:0]  resp_payload_len = '0, rm_acc_id = '0;
   logic [15:0] rm_ele_id = '0;
   logic [47:0] rm_addr = '0;
   logic [15:0] addr_0, addr_2;
   logic [7:0]  data_0 = '0, data_2 = '0;
   logic        oe_0, oe_2;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_sof, tx_eof;
   logic        tx_ready = 1'b1;
   logic        busy;
   logic [15:0] pkt_count;

   ecpri_tx dut (
      .clk(clk), .reset(reset),
      .send_read_resp(send_read_resp), .send_write_resp(send_write_resp),
      .resp_payload_len(resp_payload_len), .rm_acc_id(rm_acc_id),
      .rm_ele_id(rm_ele_id), .rm_addr(rm_addr),
      .addr_0(addr_0), .data_0(data_0), .oe_0(oe_0),
      .addr_2(addr_2), .data_2(data_2), .oe_2(oe_2),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_sof(tx_sof), .tx_eof(tx_eof),
      .tx_ready(tx_ready), .busy(busy), .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   logic [7:0] hdr_mem [16];
   logic [7:0] pl_mem  [256];

   always @(posedge clk) begin
      if (oe_0) data_0 <= hdr_mem[addr_0[3:0]];
      if (oe_2) data_2 <= pl_mem[addr_2[7:0]];
   end

   bit rand_ready = 1'b0;
   always @(posedge clk) begin
      #1;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   int n_checks = 0, n_pass = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Monitor: collect transferred bytes, check hold-while-stalled, track RAM port 2 and busy gaps.
   logic [7:0] rx_data_q[$];
   bit         rx_sof_q[$], rx_eof_q[$];
   int         frames_seen = 0, frames_used = 0;
   bit         stall_prev = 1'b0;
   logic [7:0] prev_data;
   bit         prev_sof, prev_eof;
   bit         oe2_seen = 1'b0;
   logic [15:0] max_addr2 = '0;
   int         low_run = 0, last_gap = 0;

   always @(negedge clk) begin
      if (!reset) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev)
            check("stall hold", {53'd0, tx_valid, tx_sof, tx_eof, tx_data},
                  {53'd0, 1'b1, prev_sof, prev_eof, prev_data});
         stall_prev = tx_valid && !tx_ready;
         prev_data  = tx_data;
         prev_sof   = tx_sof;
         prev_eof   = tx_eof;
         if (tx_valid && tx_ready) begin
            rx_data_q.push_back(tx_data);
            rx_sof_q.push_back(tx_sof);
            rx_eof_q.push_back(tx_eof);
            if (tx_eof) frames_seen++;
         end
         if (oe_2) begin
            oe2_seen = 1'b1;
            if (addr_2 > max_addr2) max_addr2 = addr_2;
         end
         if (!busy) low_run++;
         else begin
            if (low_run > 0) last_gap = low_run;
            low_run = 0;
         end
      end
   end

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int exp_pkts = 0;

   task automatic build_expected(input bit rd, input logic [7:0] n, input logic [7:0] acc,
                                 input logic [15:0] ele, input logic [47:0] ad);
      int ps;
      exp_q.delete();
      for (int i = 0; i < 14; i++) exp_q.push_back(hdr_mem[i]);
      ps = 12 + (rd ? int'(n) : 0);
      exp_q.push_back(8'h10);
      exp_q.push_back(8'h04);
      exp_q.push_back(8'(ps / 256));
      exp_q.push_back(8'(ps % 256));
      exp_q.push_back(acc);
      exp_q.push_back(rd ? 8'h01 : 8'h11);
      exp_q.push_back(ele[15:8]);
      exp_q.push_back(ele[7:0]);
      for (int k = 5; k >= 0; k--) exp_q.push_back(8'(ad >> (8 * k)));
      exp_q.push_back(8'h00);
      exp_q.push_back(n);
      if (rd) for (int i = 0; i < int'(n); i++) exp_q.push_back(pl_mem[i]);
   endtask

   task automatic request(input bit rd, input bit wr, input logic [7:0] n,
                          input logic [7:0] acc, input logic [15:0] ele, input logic [47:0] ad);
      send_read_resp   = rd;
      send_write_resp  = wr;
      resp_payload_len = n;
      rm_acc_id        = acc;
      rm_ele_id        = ele;
      rm_addr          = ad;
      @(posedge clk); #1;
      send_read_resp   = 1'b0;
      send_write_resp  = 1'b0;
      resp_payload_len = 8'($urandom);
      rm_acc_id        = 8'($urandom);
      rm_ele_id        = 16'($urandom);
      rm_addr          = {16'($urandom), 32'($urandom)};
   endtask

   task automatic check_frame(input string name);
      int waited = 0;
      int len;
      bit s, e;
      logic [7:0] d;
      got_q.delete();
      while (frames_seen <= frames_used && waited < 4000) begin
         @(negedge clk);
         waited++;
      end
      if (frames_seen <= frames_used) begin
         check({name, " timeout"}, 64'd0, 64'd1);
         return;
      end
      frames_used++;
      len = 0;
      while (rx_data_q.size() > 0) begin
         d = rx_data_q.pop_front();
         s = rx_sof_q.pop_front();
         e = rx_eof_q.pop_front();
         if (len < exp_q.size())
            check($sformatf("%s byte %0d", name, len), {54'd0, s, e, d},
                  {54'd0, (len == 0), (len == exp_q.size() - 1), exp_q[len]});
         got_q.push_back(d);
         len++;
         if (e) break;
      end
      check({name, " length"}, 64'(len), 64'(exp_q.size()));
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 600) begin
         @(negedge clk);
         k++;
      end
      repeat (2) @(negedge clk);
      check("wait idle", 64'(busy), 64'd0);
   endtask

   task automatic realign();
      @(posedge clk); #1;
   endtask

   typedef struct {
      bit          rd;
      logic [7:0]  n;
      logic [7:0]  acc;
      logic [15:0] ele;
      logic [47:0] ad;
      bit          rr;
      int          exp_len;
      logic [15:0] exp_ps;
      logic [7:0]  exp_b1;
   } vec_t;

   vec_t tbl[6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 16; i++) hdr_mem[i] = 8'($urandom);
      for (int i = 0; i < 256; i++) pl_mem[i] = 8'($urandom);
      pl_mem[0] = 8'hA0; pl_mem[1] = 8'hA1; pl_mem[2] = 8'hA2; pl_mem[3] = 8'hA3;

      tbl[0] = '{1'b0, 8'd0,   8'h5A, 16'h0123, 48'h0000_DEAD_BEEF, 1'b0, 30,  16'h000C, 8'h11};
      tbl[1] = '{1'b1, 8'd4,   8'h11, 16'h2222, 48'h1234_5678_9ABC, 1'b0, 34,  16'h0010, 8'h01};
      tbl[2] = '{1'b1, 8'd0,   8'h33, 16'hFFFF, 48'hFFFF_FFFF_FFFF, 1'b0, 30,  16'h000C, 8'h01};
      tbl[3] = '{1'b1, 8'd4,   8'h44, 16'h0F0F, 48'hA5A5_5A5A_0001, 1'b1, 34,  16'h0010, 8'h01};
      tbl[4] = '{1'b0, 8'd7,   8'h77, 16'h8001, 48'h0000_0000_0000, 1'b1, 30,  16'h000C, 8'h11};
      tbl[5] = '{1'b1, 8'd255, 8'h99, 16'h1357, 48'h0102_0304_0506, 1'b0, 285, 16'h010B, 8'h01};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset outputs", {2'd0, addr_0, addr_2, oe_0, oe_2, tx_data, tx_valid, tx_sof, tx_eof,
                              busy, pkt_count}, 64'd0);
      realign();
      reset = 1'b1;
      realign();

      for (int v = 0; v < 6; v++) begin
         build_expected(tbl[v].rd, tbl[v].n, tbl[v].acc, tbl[v].ele, tbl[v].ad);
         oe2_seen   = 1'b0;
         max_addr2  = '0;
         rand_ready = tbl[v].rr;
         request(tbl[v].rd, !tbl[v].rd, tbl[v].n, tbl[v].acc, tbl[v].ele, tbl[v].ad);
         check_frame($sformatf("vec%0d", v));
         wait_idle();
         rand_ready = 1'b0;
         exp_pkts++;
         check($sformatf("vec%0d pkt_count", v), 64'(pkt_count), 64'(exp_pkts));
         check($sformatf("vec%0d table length", v), 64'(got_q.size()), 64'(tbl[v].exp_len));
         check($sformatf("vec%0d PS", v), {48'd0, got_q[16], got_q[17]}, 64'(tbl[v].exp_ps));
         check($sformatf("vec%0d RMA byte1", v), 64'(got_q[19]), 64'(tbl[v].exp_b1));
         if (tbl[v].rd && tbl[v].n != 8'd0)
            check($sformatf("vec%0d last addr_2", v), 64'(max_addr2), 64'(tbl[v].n - 8'd1));
         else
            check($sformatf("vec%0d oe_2 unused", v), 64'(oe2_seen), 64'd0);
         realign();
      end

      // Simultaneous read+write requests: read first, one idle cycle of busy between frames.
      request(1'b1, 1'b1, 8'd3, 8'hC3, 16'hBEEF, 48'hCAFE_0000_F00D);
      build_expected(1'b1, 8'd3, 8'hC3, 16'hBEEF, 48'hCAFE_0000_F00D);
      check_frame("dual read");
      build_expected(1'b0, 8'd3, 8'hC3, 16'hBEEF, 48'hCAFE_0000_F00D);
      check_frame("dual write");
      check("dual busy gap", 64'(last_gap), 64'd1);
      wait_idle();
      exp_pkts += 2;
      check("dual pkt_count", 64'(pkt_count), 64'(exp_pkts));
      realign();

      // Repeat pulse while pending is dropped; first request's fields win.
      request(1'b0, 1'b1, 8'd9, 8'h01, 16'h0203, 48'h0405_0607_0809);
      repeat (3) realign();
      request(1'b1, 1'b0, 8'd2, 8'hAA, 16'hAAAA, 48'hAAAA_AAAA_AAAA);
      request(1'b1, 1'b0, 8'd5, 8'hBB, 16'hBBBB, 48'hBBBB_BBBB_BBBB);
      build_expected(1'b0, 8'd9, 8'h01, 16'h0203, 48'h0405_0607_0809);
      check_frame("queued write");
      build_expected(1'b1, 8'd2, 8'hAA, 16'hAAAA, 48'hAAAA_AAAA_AAAA);
      check_frame("queued read");
      repeat (100) @(negedge clk);
      check("repeat dropped", {31'd0, busy, 32'(frames_seen - frames_used)}, 64'd0);
      exp_pkts += 2;
      check("queued pkt_count", 64'(pkt_count), 64'(exp_pkts));
      realign();

      // Reset mid-payload with a write pending: everything clears, next frame is whole.
      request(1'b1, 1'b0, 8'd8, 8'h12, 16'h3456, 48'h789A_BCDE_F012);
      repeat (4) realign();
      request(1'b0, 1'b1, 8'd0, 8'h55, 16'h5555, 48'h5555_5555_5555);
      begin
         int k = 0;
         while (!(oe_2 && addr_2 == 16'd2) && k < 1000) begin
            @(negedge clk);
            k++;
         end
         check("reached payload", 64'(oe_2 && addr_2 == 16'd2), 64'd1);
      end
      #1 reset = 1'b0;
      @(negedge clk);
      check("mid reset outputs", {2'd0, addr_0, addr_2, oe_0, oe_2, tx_data, tx_valid, tx_sof,
                                  tx_eof, busy, pkt_count}, 64'd0);
      rx_data_q.delete();
      rx_sof_q.delete();
      rx_eof_q.delete();
      frames_used = frames_seen;
      exp_pkts = 0;
      realign();
      reset = 1'b1;
      repeat (10) @(negedge clk);
      check("pending cleared", {31'd0, busy, 32'(frames_seen - frames_used)}, 64'd0);
      realign();
      request(1'b0, 1'b1, 8'd0, 8'h5A, 16'h0123, 48'h0000_DEAD_BEEF);
      build_expected(1'b0, 8'd0, 8'h5A, 16'h0123, 48'h0000_DEAD_BEEF);
      check_frame("after reset");
      wait_idle();
      exp_pkts++;
      check("after reset pkt_count", 64'(pkt_count), 64'(exp_pkts));
      realign();

      // Random frames against the model.
      for (int r = 0; r < 8; r++) begin
         bit          rd;
         logic [7:0]  n, acc;
         logic [15:0] ele;
         logic [47:0] ad;
         rd  = 1'($urandom_range(0, 1));
         n   = 8'($urandom_range(0, 20));
         acc = 8'($urandom);
         ele = 16'($urandom);
         ad  = {16'($urandom), 32'($urandom)};
         rand_ready = 1'($urandom_range(0, 1));
         build_expected(rd, n, acc, ele, ad);
         request(rd, !rd, n, acc, ele, ad);
         check_frame($sformatf("rand%0d", r));
         wait_idle();
         rand_ready = 1'b0;
         exp_pkts++;
         check($sformatf("rand%0d pkt_count", r), 64'(pkt_count), 64'(exp_pkts));
         realign();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
